// File: rtl/if_stage_pipe_ctrl_pkg.sv
// Shared fetch-stage definitions.
// Holds the instruction NOP encoding, the PC step size, the default reset PC,
// and the priority decoders that pick the PC and IF/ID next-state sources.
package if_stage_pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Source of the next PC value
  typedef enum logic [1:0] {
    PC_SEL_STEP     = 2'd0,
    PC_SEL_HOLD     = 2'd1,
    PC_SEL_REDIRECT = 2'd2
  } pc_sel_e;

  // Source of the next IF/ID register contents
  typedef enum logic [1:0] {
    IFID_SEL_LOAD   = 2'd0,
    IFID_SEL_HOLD   = 2'd1,
    IFID_SEL_BUBBLE = 2'd2
  } ifid_sel_e;

  // A taken redirect always wins over a load-use hold on the PC.
  function automatic pc_sel_e pc_select(input logic redirect, input logic hold);
    if (redirect) begin
      return PC_SEL_REDIRECT;
    end else if (hold) begin
      return PC_SEL_HOLD;
    end else begin
      return PC_SEL_STEP;
    end
  endfunction

  // A flush (explicit or implied by a redirect) squashes IF/ID even when held.
  function automatic ifid_sel_e ifid_select(input logic flush, input logic redirect,
                                            input logic hold);
    if (flush || redirect) begin
      return IFID_SEL_BUBBLE;
    end else if (hold) begin
      return IFID_SEL_HOLD;
    end else begin
      return IFID_SEL_LOAD;
    end
  endfunction

endpackage

// File: rtl/if_stage_pipe_ctrl_if.sv
// Hazard-control / fetch bus between the hazard unit, imem and the IF stage.
// The master side issues hold/flush/redirect requests and supplies the imem
// read data; the slave side (the IF stage) returns the fetch PC, the IF/ID
// register contents and the stall/flush event counters.
interface if_stage_pipe_ctrl_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);

  logic               pc_hold_i;
  logic               ifid_hold_i;
  logic               if_flush_i;
  logic               redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic [INSTR_W-1:0] imem_instr_i;
  logic               cnt_clr_i;
  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    ifid_pc4_o;
  logic [INSTR_W-1:0] ifid_instr_o;
  logic               ifid_valid_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  modport master (
    output pc_hold_i, ifid_hold_i, if_flush_i, redirect_i, redirect_pc_i,
    output imem_instr_i, cnt_clr_i,
    input  pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pc_hold_i, ifid_hold_i, if_flush_i, redirect_i, redirect_pc_i,
    input  imem_instr_i, cnt_clr_i,
    output pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/if_stage_pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Counts up while inc_i is high, sticks at all-ones, and clears to zero when
// clr_i is high (clear wins over a same-cycle increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max_s;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d    = cnt_q;
    at_max_s = (cnt_q == {CNT_W{1'b1}});
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && !at_max_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by the asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_stage_pipe_ctrl.sv
// Instruction-fetch stage pipeline control.
// Owns the PC and the IF/ID register and applies hold, flush and redirect
// requests from the hazard unit and branch resolution. Also keeps saturating
// stall and flush event counters for the per-core performance readout.
// Every output comes straight from a flop.
module if_stage_pipe_ctrl
  import if_stage_pipe_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT[PC_W-1:0],
  parameter int              CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  if_stage_pipe_ctrl_if.slave  bus
);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    ifid_pc4_q;
  logic [PC_W-1:0]    ifid_pc4_d;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic               ifid_valid_q;
  logic               ifid_valid_d;

  logic [PC_W-1:0]    pc_plus4_s;
  pc_sel_e            pc_sel_s;
  ifid_sel_e          ifid_sel_s;
  logic               stall_inc_s;
  logic               flush_inc_s;
  logic [CNT_W-1:0]   stall_cnt_s;
  logic [CNT_W-1:0]   flush_cnt_s;

  // Priority decode of the request lines and the sequential fetch address
  always_comb begin
    pc_plus4_s  = pc_q + PC_W'(PC_STEP);
    pc_sel_s    = pc_select(bus.redirect_i, bus.pc_hold_i);
    ifid_sel_s  = ifid_select(bus.if_flush_i, bus.redirect_i, bus.ifid_hold_i);
    stall_inc_s = bus.pc_hold_i & ~bus.redirect_i;
    flush_inc_s = bus.if_flush_i | bus.redirect_i;
  end

  // PC next-state: redirect target, held value, or PC + 4 (wraps silently)
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_s)
      PC_SEL_REDIRECT: pc_d = bus.redirect_pc_i;
      PC_SEL_HOLD:     pc_d = pc_q;
      PC_SEL_STEP:     pc_d = pc_plus4_s;
      default:         pc_d = pc_q;
    endcase
  end

  // IF/ID next-state: bubble on flush/redirect, keep on hold, else latch fetch
  always_comb begin
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    case (ifid_sel_s)
      IFID_SEL_BUBBLE: begin
        ifid_pc4_d   = {PC_W{1'b0}};
        ifid_instr_d = INSTR_W'(NOP_INSTR);
        ifid_valid_d = 1'b0;
      end
      IFID_SEL_HOLD: begin
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
      end
      IFID_SEL_LOAD: begin
        ifid_pc4_d   = pc_plus4_s;
        ifid_instr_d = bus.imem_instr_i;
        ifid_valid_d = 1'b1;
      end
      default: begin
        ifid_pc4_d   = {PC_W{1'b0}};
        ifid_instr_d = INSTR_W'(NOP_INSTR);
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // PC register; reset restarts fetch at RESET_PC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID register; reset leaves a NOP bubble in ID
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc4_q   <= {PC_W{1'b0}};
      ifid_instr_q <= INSTR_W'(NOP_INSTR);
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Cycles where the PC is held and not overridden by a redirect
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc_s),
    .clr_i (bus.cnt_clr_i),
    .cnt_o (stall_cnt_s)
  );

  // Cycles where IF/ID is squashed, either explicitly or by a redirect
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc_s),
    .clr_i (bus.cnt_clr_i),
    .cnt_o (flush_cnt_s)
  );

  assign bus.pc_o         = pc_q;
  assign bus.ifid_pc4_o   = ifid_pc4_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.stall_cnt_o  = stall_cnt_s;
  assign bus.flush_cnt_o  = flush_cnt_s;

endmodule

// File: tb/tb_if_stage_pipe_ctrl.sv
// Directed bench for if_stage_pipe_ctrl: a reference model pushes the
// expected post-edge state into a scoreboard queue when each step is driven,
// and the entry is popped and compared once the edge has happened.
module tb_if_stage_pipe_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   step_no;
  exp_t sb[$];

  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  if_stage_pipe_ctrl_if bus ();

  if_stage_pipe_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_pc4   = 32'h0000_0000;
    m_instr = 32'h0000_0000;
    m_valid = 1'b0;
    m_stall = 16'h0000;
    m_flush = 16'h0000;
  endtask

  task automatic check_outputs(input exp_t e);
    check("pc", 64'(bus.pc_o), 64'(e.pc));
    check("ifid_pc4", 64'(bus.ifid_pc4_o), 64'(e.pc4));
    check("ifid_instr", 64'(bus.ifid_instr_o), 64'(e.instr));
    check("ifid_valid", 64'(bus.ifid_valid_o), 64'(e.valid));
    check("stall_cnt", 64'(bus.stall_cnt_o), 64'(e.stall));
    check("flush_cnt", 64'(bus.flush_cnt_o), 64'(e.flush));
  endtask

  // Drive one cycle of requests, predict the post-edge state, then compare.
  task automatic step(input logic ph, input logic ih, input logic fl, input logic rd,
                      input logic [31:0] rpc, input logic [31:0] instr, input logic clr);
    exp_t e;
    exp_t got;
    bus.pc_hold_i     = ph;
    bus.ifid_hold_i   = ih;
    bus.if_flush_i    = fl;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.imem_instr_i  = instr;
    bus.cnt_clr_i     = clr;
    if (rd)      e.pc = rpc;
    else if (ph) e.pc = m_pc;
    else         e.pc = m_pc + 32'd4;
    if (fl || rd) begin
      e.pc4 = 32'h0; e.instr = 32'h0; e.valid = 1'b0;
    end else if (ih) begin
      e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid;
    end else begin
      e.pc4 = m_pc + 32'd4; e.instr = instr; e.valid = 1'b1;
    end
    if (clr)                             e.stall = 16'h0;
    else if (ph && !rd && m_stall != 16'hFFFF) e.stall = m_stall + 16'd1;
    else                                 e.stall = m_stall;
    if (clr)                             e.flush = 16'h0;
    else if ((fl || rd) && m_flush != 16'hFFFF) e.flush = m_flush + 16'd1;
    else                                 e.flush = m_flush;
    sb.push_back(e);
    m_pc = e.pc; m_pc4 = e.pc4; m_instr = e.instr; m_valid = e.valid;
    m_stall = e.stall; m_flush = e.flush;
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      got = sb.pop_front();
      check_outputs(got);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] pc);
    return {pc[15:0], 16'hA5C3} ^ 32'h1357_9BDF;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    rst     = 1'b1;
    bus.pc_hold_i = 1'b0; bus.ifid_hold_i = 1'b0; bus.if_flush_i = 1'b0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0; bus.imem_instr_i = 32'h0;
    bus.cnt_clr_i = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_pc", 64'(bus.pc_o), 64'h0);
    check("rst_pc4", 64'(bus.ifid_pc4_o), 64'h0);
    check("rst_instr", 64'(bus.ifid_instr_o), 64'h0);
    check("rst_valid", 64'(bus.ifid_valid_o), 64'h0);
    check("rst_stall", 64'(bus.stall_cnt_o), 64'h0);
    check("rst_flush", 64'(bus.flush_cnt_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running fetch with a fixed imem word
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2001_0005, 1'b0);
    check("free_pc4_1", 64'(bus.ifid_pc4_o), 64'd4);
    check("free_valid", 64'(bus.ifid_valid_o), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2001_0005, 1'b0);
    check("free_pc_8", 64'(bus.pc_o), 64'd8);

    // Full hold for two cycles at pc = 8, then release
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    check("hold_pc", 64'(bus.pc_o), 64'd8);
    check("hold_instr", 64'(bus.ifid_instr_o), 64'h2001_0005);
    check("hold_stall2", 64'(bus.stall_cnt_o), 64'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2001_0005, 1'b0);
    check("release_pc", 64'(bus.pc_o), 64'd12);

    // Redirect beats pc_hold and squashes the wrong-path fetch
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, pat(m_pc), 1'b0);
    check("redir_pc", 64'(bus.pc_o), 64'h40);
    check("redir_valid", 64'(bus.ifid_valid_o), 64'd0);
    check("redir_flush1", 64'(bus.flush_cnt_o), 64'd1);
    check("redir_stall", 64'(bus.stall_cnt_o), 64'd2);

    // Flush beats ifid_hold while the PC keeps advancing
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, pat(m_pc), 1'b0);
    check("flush_valid", 64'(bus.ifid_valid_o), 64'd0);
    check("flush_pc", 64'(bus.pc_o), 64'h48);

    // PC hold alone re-latches the same fetch; ifid hold alone freezes ID
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);

    // Address wrap from the top of the space
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, pat(m_pc), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    check("wrap_pc", 64'(bus.pc_o), 64'h0);
    check("wrap_pc4", 64'(bus.ifid_pc4_o), 64'h0);
    check("wrap_valid", 64'(bus.ifid_valid_o), 64'd1);

    // Clear overrides a same-cycle stall increment
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b1);
    check("clr_stall", 64'(bus.stall_cnt_o), 64'd0);

    // Drive the stall counter to 16'hFFFE, then three more to saturate
    for (int i = 0; i < 65534; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    end
    check("stall_fffe", 64'(bus.stall_cnt_o), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b0);
    end
    check("stall_sat", 64'(bus.stall_cnt_o), 64'hFFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, pat(m_pc), 1'b1);
    check("sat_clr", 64'(bus.stall_cnt_o), 64'd0);

    // Move off RESET_PC, then assert reset mid-cycle during a stall
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1230, pat(m_pc), 1'b0);
    bus.pc_hold_i = 1'b1;
    bus.if_flush_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pc", 64'(bus.pc_o), 64'h0);
    check("midrst_flush", 64'(bus.flush_cnt_o), 64'h0);
    check("midrst_valid", 64'(bus.ifid_valid_o), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2001_0005, 1'b0);
    check("post_rst_pc", 64'(bus.pc_o), 64'd4);
    check("post_rst_pc4", 64'(bus.ifid_pc4_o), 64'd4);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_pipe_ctrl.md
Name: if_stage_pipe_ctrl

Overview:
Consumer end of the hazard-control interface in the pipelined multi-core CPU. It owns the PC register and the IF/ID pipeline register, and applies the hold, flush and redirect requests issued by the hazard-detection unit and by branch resolution. One instance sits per core, between instruction memory and the ID stage. Saturating stall and flush event counters are exposed for the per-core performance readout.

Parameters:
PC_W, 32, PC and address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of each event counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
pc_hold_i  in  1  1 = hold PC (load-use stall)
ifid_hold_i  in  1  1 = hold IF/ID contents
if_flush_i  in  1  1 = turn IF/ID into a bubble at the next edge
redirect_i  in  1  branch/jump resolved taken
redirect_pc_i  in  PC_W  redirect target
imem_instr_i  in  INSTR_W  instruction at pc_o (combinational imem read)
cnt_clr_i  in  1  synchronous clear of both counters
pc_o  out  PC_W  current fetch PC
ifid_pc4_o  out  PC_W  registered PC+4 of the instruction in ID
ifid_instr_o  out  INSTR_W  registered instruction in ID
ifid_valid_o  out  1  1 = ID holds a real instruction
stall_cnt_o  out  CNT_W  cycles with pc_hold_i=1 and no redirect
flush_cnt_o  out  CNT_W  cycles with if_flush_i=1 or redirect_i=1

Behaviour:
- Reset is asynchronous. While rst_i is high:
  - pc_o = RESET_PC
  - ifid_pc4_o = 0, ifid_instr_o = 0 (NOP), ifid_valid_o = 0
  - both counters = 0
- Reset asserted mid-stall or mid-flush overrides everything immediately. The first edge after release fetches RESET_PC.
- PC next-state, evaluated in priority order:
  1. redirect_i=1 -> redirect_pc_i. Redirect beats pc_hold_i.
  2. pc_hold_i=1 -> pc_o unchanged.
  3. Otherwise -> pc_o + 4, modulo 2^PC_W. Wrap from 32'hFFFF_FFFC goes to 0 with no flag.
- IF/ID next-state, evaluated in priority order:
  1. if_flush_i=1 or redirect_i=1 -> instr = 0, valid = 0, pc4 = 0. Flush beats ifid_hold_i.
  2. ifid_hold_i=1 -> all IF/ID fields unchanged.
  3. Otherwise -> pc4 = pc_o + 4, instr = imem_instr_i, valid = 1.
- Hold signals are independent. pc_hold_i=1 with ifid_hold_i=0 re-latches the same fetch; this is legal.
- Latency:
  - Instruction at pc_o appears on ifid_instr_o one edge later.
  - A redirect affects pc_o one edge later. The wrong-path instruction is squashed at that same edge.
- Counters:
  - stall_cnt increments when pc_hold_i=1 and redirect_i=0.
  - flush_cnt increments when (if_flush_i | redirect_i) = 1.
  - Both saturate at all-ones with no wrap.
  - cnt_clr_i forces both to 0 and overrides the increment in the same cycle.
- All outputs are registered; nothing combinational runs from inputs to outputs.

Decomposition:
- Shared cpu_pkg holds:
  - constant NOP_INSTR = 32'h0000_0000
  - constant PC_STEP = 4
  - RESET_PC default
- One sub-module, sat_counter, is instantiated twice. It takes CNT_W, inc, clr and the async reset.
- PC and IF/ID registers stay in the top module.

Test Plan:
- Reset then 4 free-running cycles, imem returns 32'h2001_0005 -> pc_o = 0, 4, 8, 12; ifid_instr = 32'h2001_0005, ifid_valid = 1 from cycle 1; ifid_pc4 = 4, 8, 12.
- pc_hold_i = ifid_hold_i = 1 for 2 cycles at pc = 8 -> pc_o stays 8; IF/ID unchanged; stall_cnt = 2; cycle after release, pc_o = 12.
- redirect_i = 1 with redirect_pc_i = 32'h40 while pc_hold_i = 1 -> next pc_o = 32'h40; ifid_valid = 0, ifid_instr = 0; flush_cnt = 1, stall_cnt not incremented.
- if_flush_i = 1 with ifid_hold_i = 1 -> IF/ID becomes bubble (valid = 0); PC advances if pc_hold_i = 0.
- pc_o = 32'hFFFF_FFFC, no hold -> pc_o = 0; ifid_pc4 = 0.
- Force stall_cnt = 16'hFFFE, hold 3 cycles -> saturates at 16'hFFFF. Then cnt_clr_i with pc_hold_i = 1 -> 0. rst_i asserted mid-cycle -> pc_o = RESET_PC before the next edge.
